// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX stage ALU.
// Latency: WIDTH+1 cycles for normal ops, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: md_stall holds the pipeline while an M op is in ID/EX and the result is not yet presented.
module ex_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_valid,
    input  logic [2:0]       md_funct3,
    input  logic [WIDTH-1:0] md_op_a,
    input  logic [WIDTH-1:0] md_op_b,
    input  logic             flush,
    output logic             md_stall,
    output logic             md_busy,
    output logic [WIDTH-1:0] md_result,
    output logic             md_result_valid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2:0]       op;
    logic [WIDTH-1:0] opd;   // multiplicand for MUL*, divisor for DIV*/REM*
    logic [WIDTH-1:0] hi;    // product high half / partial remainder
    logic [WIDTH-1:0] lo;    // multiplier shifting out / dividend shifting into quotient
    logic             neg_q;
    logic             neg_r;

    // Operand decode for the instruction sitting in ID/EX
    logic             is_div, a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             div_zero, div_ovf, special, start;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        is_div   = md_funct3[2];
        a_signed = is_div ? ~md_funct3[0] : (md_funct3[1:0] == 2'b01 || md_funct3[1:0] == 2'b10);
        b_signed = is_div ? ~md_funct3[0] : (md_funct3[1:0] == 2'b01);
        a_neg    = a_signed & md_op_a[WIDTH-1];
        b_neg    = b_signed & md_op_b[WIDTH-1];
        a_abs    = a_neg ? -md_op_a : md_op_a;
        b_abs    = b_neg ? -md_op_b : md_op_b;
        div_zero = is_div & (md_op_b == '0);
        div_ovf  = is_div & ~md_funct3[0] & (md_op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (md_op_b == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = md_funct3[1] ? md_op_a : '1;
        else
            special_res = md_funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        start = (state == S_IDLE) & md_valid & ~flush;
    end

    // One shift-add or restoring-divide iteration
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s, fin_res;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opd};
        div_ge    = ~div_diff[WIDTH+1];
        if (op[2]) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
        prod    = {step_hi, step_lo};
        prod_s  = neg_q ? -prod : prod;
        quot_s  = neg_q ? -step_lo : step_lo;
        rem_s   = neg_r ? -step_hi : step_hi;
        fin_res = prod_s[2*WIDTH-1:WIDTH];
        case (op)
            3'd0:       fin_res = prod_s[WIDTH-1:0];
            3'd4, 3'd5: fin_res = quot_s;
            3'd6, 3'd7: fin_res = rem_s;
            default:    fin_res = prod_s[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (md_valid) state_nxt = special ? S_DONE : S_CALC;
            S_CALC:  if (cnt == LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op        <= '0;
            opd       <= '0;
            hi        <= '0;
            lo        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            md_result <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                op    <= md_funct3;
                cnt   <= '0;
                hi    <= '0;
                lo    <= is_div ? a_abs : b_abs;
                opd   <= is_div ? b_abs : a_abs;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                if (special)
                    md_result <= special_res;
            end else if (state == S_CALC && !flush) begin
                hi  <= step_hi;
                lo  <= step_lo;
                cnt <= cnt + 1'b1;
                if (cnt == LAST)
                    md_result <= fin_res;
            end
        end
    end

    assign md_stall        = md_valid & ~flush & (state != S_DONE);
    assign md_busy         = (state == S_CALC);
    assign md_result_valid = (state == S_DONE) & ~flush;

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative RV32M multiply/divide sequencer beside the EX stage ALU. When an M-extension instruction sits in ID/EX, it latches the forwarded operands, stalls the pipeline, and runs a radix-2 shift-add multiply or restoring divide. It then presents the 32-bit result for one cycle, so the EX result mux selects it instead of the ALU output. It also aborts cleanly on a pipeline flush.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH (only 32 is verified)
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- md_valid  in  1  ID/EX holds an M op (opcode R-type, funct7 = 7'b0000001)
- md_funct3  in  3  M op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- md_op_a  in  WIDTH  rs1 value after forwarding mux A
- md_op_b  in  WIDTH  rs2 value after forwarding mux B (never the immediate)
- flush  in  1  kill the instruction in EX (branch taken / trap)
- md_stall  out  1  hold PC, IF/ID and ID/EX; insert bubble into EX/MEM
- md_busy  out  1  state is CALC
- md_result  out  WIDTH  result, valid only while md_result_valid
- md_result_valid  out  1  result ready; EX result mux selects md_result

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - If md_valid & ~flush, latch md_funct3 and the operands, clear the counter, and go to CALC.
  - Special divide cases go directly to DONE with their result preloaded.
- CALC:
  - Performs one iteration per cycle; the counter runs 0..WIDTH-1.
  - On count == WIDTH-1, apply the sign fix-up, load md_result and go to DONE.
  - md_valid, md_op_a, md_op_b and md_funct3 are ignored while in CALC.
- DONE: md_result_valid = 1; unconditionally go to IDLE on the next edge.
- flush: highest priority after rst. From any state, go to IDLE with md_result_valid = 0 next cycle; the counter and partial results are discarded.
- md_stall = md_valid & ~flush & (state != DONE). This is combinational, so an M op stalls in the same cycle it enters EX.
- Multiply:
  - Form magnitudes of the operands according to signedness: MULH both operands signed, MULHSU op_a signed and op_b unsigned, MULHU and MUL unsigned.
  - Run a 64-bit unsigned shift-add.
  - Negate the product when exactly one signed operand is negative.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide:
  - DIV/REM take magnitudes; DIVU/REMU are unsigned.
  - Use a restoring divide with a 33-bit partial remainder.
  - Quotient sign is sign(a) xor sign(b); remainder sign equals sign(a).
- Special cases, resolved in IDLE:
  - Divisor 0: quotient = 32'hFFFFFFFF, remainder = op_a (all four divide ops).
  - DIV/REM with op_a = 32'h80000000 and op_b = 32'hFFFFFFFF: quotient = 32'h80000000, remainder = 0.
- Reset values: state IDLE, counter 0, md_result 0, md_result_valid 0, md_busy 0. md_stall then follows md_valid.

## Timing
- Normal op entering EX at cycle T:
  - Stall is high for T..T+WIDTH (33 cycles).
  - md_result_valid is high on cycle T+WIDTH+1 only, with md_stall = 0 on that cycle.
  - The pipeline advances at the end of T+WIDTH+1.
- Special divide case: stall on T only; result valid on T+1.
- Back-to-back M ops:
  - The second op enters EX on the cycle after DONE, with the FSM in IDLE.
  - It starts immediately, with no dead cycle beyond DONE.
- A flush on the same cycle as DONE drops md_result_valid that cycle; the result must not be written back.
- rst mid-CALC: IDLE next cycle, all outputs at reset values.
- md_result holds its last value outside DONE; consumers qualify it with md_result_valid.

## Test plan
- MUL 7 × -3 (op_b = 32'hFFFFFFFD) → result 32'hFFFFFFEB. Stall high for exactly 33 cycles, then md_result_valid for 1 cycle.
- MULH 32'h80000000 × 32'h80000000 → 32'h40000000. MULHSU with -1 × 32'hFFFFFFFF → 32'hFFFFFFFF. MULHU with 32'hFFFFFFFF × 32'hFFFFFFFF → 32'hFFFFFFFE.
- DIV -7 / 2 → 32'hFFFFFFFD and REM -7 / 2 → 32'hFFFFFFFF; DIVU 100 / 7 → 14 and REMU 100 / 7 → 2.
- DIVU x / 0 → 32'hFFFFFFFF; REM 32'h80000000 / -1 → 0. Both have a 1-cycle stall, with the result valid on T+1.
- Flush at CALC count 10:
  - Required: IDLE next cycle, no md_result_valid.
  - Then a new MULHU 3 × 5 entering EX the cycle after the flush → 0 after a full 33-cycle stall.
- Two back-to-back DIVs (20/4 then 9/3) → results 5 then 3. No stall gap beyond the DONE cycle; rst asserted mid-second op yields all outputs zero next cycle.
